sng_lfsr_bank: RTL and testbench
================================

Name: sng_lfsr_bank

Overview:
Multi-channel stochastic number generator (SNG). It holds one registered Fibonacci LFSR. It emits CHANNELS parallel unipolar bitstreams, where each bit is (LFSR view < channel probability). It counts stream length and per-channel ones, and supports early termination through a stop input. It sits between the binary operand registers and the SC arithmetic/early-termination datapath, and replaces the free-running combinational LFSR + external state register arrangement.

Parameters:
WIDTH, 8, LFSR width = probability precision = counter width.
CHANNELS, 2, number of output bitstreams.
POLY, 8'hB8, Fibonacci tap mask (bit i set = state[i] in feedback XOR); default is maximal for WIDTH=8.
SEED, 1, LFSR reload value on start; must be nonzero.
SHARED, 0, 1 = all channels compare against the same LFSR value (SCC=+1); 0 = channel c compares against state rotated left by c bits.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  begin a stream; sampled only in IDLE.
stop  in  1  early-termination request; sampled only in RUN.
len  in  WIDTH  stream length in cycles; 0 = full period 2^WIDTH-1.
prob  in  CHANNELS*WIDTH  per-channel probability numerators; channel c = prob[c*WIDTH +: WIDTH].
busy  out  1  high in RUN and DONE.
bits_valid  out  1  high exactly in RUN cycles.
bits_out  out  CHANNELS  stream bits, valid when bits_valid.
done  out  1  one-cycle pulse after the final stream bit.
stream_len  out  WIDTH  number of bits emitted in the last or current stream.
ones_count  out  CHANNELS*WIDTH  per-channel count of 1 bits emitted.

Behaviour:
- Reset (rst=1 at edge, any state): FSM->IDLE; lfsr<=SEED; cnt, ones, prob/len latches <=0. All outputs are 0 in the following cycle.
- LFSR step: fb = ^(state & POLY); next = {state[WIDTH-2:0], fb}. It advances only in RUN.
- View for channel c: SHARED ? state : rotl(state, c mod WIDTH). bits_out[c] = view_c < prob_lat[c] (unsigned, combinational from registers). The output is forced to 0 outside RUN.
- FSM IDLE: when start=1, latch prob and len (len 0 -> 2^WIDTH-1), lfsr<=SEED, cnt<=0, ones<=0, and go to RUN. When start=0, stay in IDLE and hold stream_len/ones_count from the previous stream.
- FSM RUN: each cycle the bits are valid. Then lfsr steps, cnt<=cnt+1, and ones[c]<=ones[c]+bits_out[c]. The first valid bit is the cycle after start is accepted, and it uses state=SEED.
- RUN -> DONE: at the edge where cnt==len_lat-1 or stop==1. The bits of that cycle are still valid and counted. If stop and the last count coincide, there is a single transition.
- FSM DONE: lasts one cycle, with done=1 and busy=1. Counters are frozen. It then goes to IDLE. start during RUN or DONE is ignored (not queued).
- stream_len = cnt, ones_count = ones; both are live during RUN and held after DONE until the next accepted start.
- Width: ones and cnt never exceed 2^WIDTH-1, so no overflow is possible.
- Full-period property: over 2^WIDTH-1 steps from any nonzero seed, each view visits every nonzero value exactly once. Therefore ones[c] = max(prob[c]-1, 0).
- Determinism: the LFSR reloads SEED on every start, so identical inputs give identical streams.

Test Plan:
1. Reset: hold rst 3 cycles with start=1 -> busy, bits_valid, done, stream_len, ones_count all 0. The first start after release is accepted.
2. SHARED=0, len=0, prob={ch1=128, ch0=1} -> 255 valid cycles, done pulses once, stream_len=255, ones={127,0}. prob={255,0} -> ones={254,0}.
3. SHARED=1, len=0, prob={50,100}, bench ANDs bits_out[0]&bits_out[1] -> AND count=49, ones={49,99}.
4. len=16, stop asserted in the 11th valid cycle -> exactly 11 valid cycles, stream_len=11, done 1 cycle after, ones equal the bench count of those 11 bits.
5. len=16, start held high throughout a run, then a second run with the same inputs -> the second start is accepted only from IDLE. Both runs give an identical 16-bit sequence per channel and identical ones_count.
6. Assert rst at the 5th RUN cycle -> next cycle IDLE, all outputs 0, no done pulse. A subsequent run reproduces the scenario-5 sequence.

Source files
------------

// File: rtl/sng_lfsr_bank.sv
// rtl/sng_lfsr_bank.sv - multi-channel stochastic number generator driven by one Fibonacci LFSR
// Each channel emits (LFSR view < probability) per RUN cycle; stream length and ones are counted.
module sng_lfsr_bank #(
   parameter int               WIDTH    = 8,
   parameter int               CHANNELS = 2,
   parameter logic [WIDTH-1:0] POLY     = 8'hB8,
   parameter logic [WIDTH-1:0] SEED     = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter bit               SHARED   = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      stop,
   input  logic [WIDTH-1:0]          len,
   input  logic [CHANNELS*WIDTH-1:0] prob,
   output logic                      busy,
   output logic                      bits_valid,
   output logic [CHANNELS-1:0]       bits_out,
   output logic                      done,
   output logic [WIDTH-1:0]          stream_len,
   output logic [CHANNELS*WIDTH-1:0] ones_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [WIDTH-1:0]          lfsr_q, lfsr_d;
   logic [WIDTH-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]          len_q, len_d;
   logic [CHANNELS*WIDTH-1:0] prob_q, prob_d;
   logic [CHANNELS*WIDTH-1:0] ones_q, ones_d;
   logic [CHANNELS-1:0]       bits_raw;
   logic                      run;

   // Decorrelated channels see the same register rotated left by the channel index.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam int ROT = SHARED ? 0 : (c % WIDTH);
      logic [WIDTH-1:0] view;
      if (ROT == 0) begin : g_id
         assign view = lfsr_q;
      end else begin : g_rot
         assign view = {lfsr_q[WIDTH-1-ROT:0], lfsr_q[WIDTH-1:WIDTH-ROT]};
      end
      assign bits_raw[c] = (view < prob_q[c*WIDTH +: WIDTH]);
   end

   assign run        = (state_q == S_RUN);
   assign busy       = (state_q != S_IDLE);
   assign bits_valid = run;
   assign done       = (state_q == S_DONE);
   assign bits_out   = run ? bits_raw : '0;
   assign stream_len = cnt_q;
   assign ones_count = ones_q;

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      prob_d  = prob_q;
      ones_d  = ones_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               prob_d  = prob;
               len_d   = (len == '0) ? '1 : len;
               lfsr_d  = SEED;
               cnt_d   = '0;
               ones_d  = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & POLY)};
            cnt_d  = cnt_q + WIDTH'(1);
            for (int c = 0; c < CHANNELS; c++) begin
               ones_d[c*WIDTH +: WIDTH] = ones_q[c*WIDTH +: WIDTH] + WIDTH'(bits_raw[c]);
            end
            if ((cnt_q == len_q - WIDTH'(1)) || stop) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED;
         cnt_q   <= '0;
         len_q   <= '0;
         prob_q  <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         prob_q  <= prob_d;
         ones_q  <= ones_d;
      end
   end

endmodule

// File: tb/tb_sng_lfsr_bank.sv
// tb/tb_sng_lfsr_bank.sv - scoreboard bench for sng_lfsr_bank (rotated and shared instances)
module tb_sng_lfsr_bank;

   localparam int W  = 8;
   localparam int CH = 2;
   localparam logic [W-1:0] POLY = 8'hB8;
   localparam logic [W-1:0] SEED = 8'h01;

   logic clk = 1'b0;
   logic rst, start, stop;
   logic [W-1:0] len;
   logic [CH*W-1:0] prob;

   logic busy_a, valid_a, done_a, busy_b, valid_b, done_b;
   logic [CH-1:0] bits_a, bits_b;
   logic [W-1:0] slen_a, slen_b;
   logic [CH*W-1:0] ones_a, ones_b;

   sng_lfsr_bank #(.WIDTH(W), .CHANNELS(CH), .POLY(POLY), .SEED(SEED), .SHARED(1'b0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .len(len), .prob(prob),
      .busy(busy_a), .bits_valid(valid_a), .bits_out(bits_a), .done(done_a),
      .stream_len(slen_a), .ones_count(ones_a));

   sng_lfsr_bank #(.WIDTH(W), .CHANNELS(CH), .POLY(POLY), .SEED(SEED), .SHARED(1'b1)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .len(len), .prob(prob),
      .busy(busy_b), .bits_valid(valid_b), .bits_out(bits_b), .done(done_b),
      .stream_len(slen_b), .ones_count(ones_b));

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int              n;
      logic [CH*W-1:0] ones;
      int              andc;
   } fin_t;

   logic [CH-1:0] qa[$];
   logic [CH-1:0] qb[$];
   fin_t          fa[$];
   fin_t          fb[$];

   // Reference: shift left, append parity of tapped bits; views by rotation of a doubled word.
   function automatic logic [W-1:0] step(input logic [W-1:0] s);
      int v;
      v = (int'(s) * 2) % (1 << W) + ($countones(s & POLY) % 2);
      return W'(v);
   endfunction

   function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int r);
      logic [2*W-1:0] d;
      d = {v, v} << r;
      return d[2*W-1:W];
   endfunction

   task automatic model(input int lenv, input logic [CH*W-1:0] p, input int stop_at, input bit push_fin);
      int n, andc;
      int oa[CH];
      int ob[CH];
      logic [W-1:0] s;
      logic [CH-1:0] ba, bb;
      fin_t f;
      n = (lenv == 0) ? (1 << W) - 1 : lenv;
      if (stop_at > 0 && stop_at < n) n = stop_at;
      s = SEED;
      andc = 0;
      for (int c = 0; c < CH; c++) begin
         oa[c] = 0;
         ob[c] = 0;
      end
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < CH; c++) begin
            ba[c] = (rotl(s, c % W) < p[c*W +: W]);
            bb[c] = (s < p[c*W +: W]);
            oa[c] += int'(ba[c]);
            ob[c] += int'(bb[c]);
         end
         andc += int'(&bb);
         qa.push_back(ba);
         qb.push_back(bb);
         s = step(s);
      end
      if (!push_fin) return;
      if (n == (1 << W) - 1) begin
         // Full period: each view hits every nonzero value once.
         int mn;
         mn = (1 << W);
         for (int c = 0; c < CH; c++) begin
            int pc;
            pc = int'(p[c*W +: W]);
            oa[c] = (pc > 0) ? pc - 1 : 0;
            ob[c] = oa[c];
            if (pc < mn) mn = pc;
         end
         andc = (mn > 0) ? mn - 1 : 0;
      end
      f.n = n;
      f.andc = andc;
      for (int c = 0; c < CH; c++) f.ones[c*W +: W] = W'(oa[c]);
      fa.push_back(f);
      for (int c = 0; c < CH; c++) f.ones[c*W +: W] = W'(ob[c]);
      fb.push_back(f);
   endtask

   int and_b = 0;

   always @(negedge clk) begin
      fin_t f;
      if (valid_a) begin
         if (qa.size() == 0) check("unexpected_valid_a", 1, 0);
         else check("bits_a", 64'(bits_a), 64'(qa.pop_front()));
      end
      if (!busy_b) and_b = 0;
      if (valid_b) begin
         and_b += int'(&bits_b);
         if (qb.size() == 0) check("unexpected_valid_b", 1, 0);
         else check("bits_b", 64'(bits_b), 64'(qb.pop_front()));
      end
      if (done_a) begin
         if (fa.size() == 0) check("unexpected_done_a", 1, 0);
         else begin
            f = fa.pop_front();
            check("stream_len_a", 64'(slen_a), 64'(f.n));
            check("ones_a", 64'(ones_a), 64'(f.ones));
            check("busy_in_done_a", 64'(busy_a), 1);
         end
      end
      if (done_b) begin
         if (fb.size() == 0) check("unexpected_done_b", 1, 0);
         else begin
            f = fb.pop_front();
            check("stream_len_b", 64'(slen_b), 64'(f.n));
            check("ones_b", 64'(ones_b), 64'(f.ones));
            check("and_count_b", 64'(and_b), 64'(f.andc));
         end
      end
   end

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, 64'({busy_a, busy_b}), 0);
      check({tag, "_valid"}, 64'({valid_a, valid_b}), 0);
      check({tag, "_done"}, 64'({done_a, done_b}), 0);
      check({tag, "_bits"}, 64'({bits_a, bits_b}), 0);
      check({tag, "_slen"}, 64'({slen_a, slen_b}), 0);
      check({tag, "_ones"}, 64'({ones_a, ones_b}), 0);
   endtask

   // Runs until done (or valid cycle abort_at when rst_abort), driving stop in valid cycle stop_at.
   task automatic follow(input int stop_at, input bit hold, input int abort_at);
      int k, cyc;
      k = 0;
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!hold) start = 1'b0;
         if (valid_a) begin
            k++;
            stop = (stop_at != 0 && k == stop_at);
            if (abort_at != 0 && k == abort_at) begin
               rst = 1'b1;
               break;
            end
         end else begin
            stop = 1'b0;
         end
         if (done_a) break;
         if (cyc > 400) begin
            check("timeout_waiting_done", 1, 0);
            break;
         end
      end
   endtask

   task automatic run(input int lenv, input logic [CH*W-1:0] p, input int stop_at, input bit hold);
      model(lenv, p, stop_at, 1'b1);
      @(negedge clk);
      check("idle_before_start", 64'({busy_a, busy_b}), 0);
      start = 1'b1;
      len   = W'(lenv);
      prob  = p;
      stop  = 1'b0;
      @(posedge clk);
      follow(stop_at, hold, 0);
   endtask

   logic [CH*W-1:0] p5;

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      stop  = 1'b0;
      len   = '0;
      prob  = {8'd128, 8'd1};
      model(0, prob, 0, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check_idle_zero("reset");
      end
      rst = 1'b0;
      @(posedge clk);
      follow(0, 1'b0, 0);

      run(0, {8'd255, 8'd0}, 0, 1'b0);
      run(0, {8'd50, 8'd100}, 0, 1'b0);
      run(16, {W'($urandom), W'($urandom)}, 11, 1'b0);

      p5 = {8'd90, 8'd170};
      run(16, p5, 0, 1'b1);
      run(16, p5, 0, 1'b0);

      // Abort with reset in the 5th valid cycle: no done, outputs clear next cycle.
      model(16, p5, 5, 1'b0);
      @(negedge clk);
      start = 1'b1;
      len   = 8'd16;
      prob  = p5;
      @(posedge clk);
      follow(0, 1'b0, 5);
      @(negedge clk);
      check_idle_zero("abort");
      rst = 1'b0;
      run(16, p5, 0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         int lv, sa;
         lv = (i == 0) ? 0 : int'($urandom_range(1, 40));
         sa = (i == 0) ? 0 : int'($urandom_range(0, lv + 3));
         run(lv, {W'($urandom), W'($urandom)}, sa, 1'b0);
      end

      repeat (3) @(negedge clk);
      check("leftover_expected", 64'(qa.size() + qb.size() + fa.size() + fb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
